prs_burst_ctrl: RTL and testbench



---
 rtl/prs_burst_ctrl.sv | 137 +++++++++++++
 tb/tb_prs_burst_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/prs_burst_ctrl.sv
// Burst sequencer for a prsgen8 bit generator: takes tap/length commands,
// resets and runs the generator, and packs its serial output MSB-first into bytes.
module prs_burst_ctrl #(
   parameter int unsigned LEN_W        = 8,
   parameter int unsigned RST_CYCLES   = 2,
   parameter int unsigned SKIP         = 0,
   parameter logic [7:0]  DEFAULT_TAPS = 8'hfe
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [7:0]       cmd_taps,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             abort,
   output logic             prs_reset,
   output logic [7:0]       prs_taps,
   input  logic             prs_bit,
   output logic [7:0]       byte_data,
   output logic             byte_valid,
   output logic             busy,
   output logic             done,
   output logic             aborted
);

   typedef enum logic [2:0] {S_IDLE, S_RST, S_SKIP, S_RUN, S_DONE} state_t;

   // One counter serves both the reset hold and the skip phase.
   localparam int unsigned CNT_MAX = (RST_CYCLES > SKIP) ? RST_CYCLES : SKIP;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES);
   localparam logic [CNT_W-1:0] SKIP_LOAD = CNT_W'(SKIP);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [LEN_W-1:0] rem_q;
   logic [2:0]       bit_cnt_q;
   logic [6:0]       shreg_q;

   logic prs_reset_d, busy_d, done_d, aborted_d;
   logic accept, byte_done;

   assign cmd_ready = (state_q == S_IDLE) && !reset;
   assign accept    = cmd_valid && cmd_ready;
   assign byte_done = (state_q == S_RUN) && (bit_cnt_q == 3'd7);

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept) state_d = (cmd_len == '0) ? S_DONE : S_RST;
         S_RST: begin
            if (abort)                  state_d = S_DONE;
            else if (cnt_q == CNT_LAST) state_d = (SKIP == 0) ? S_RUN : S_SKIP;
         end
         S_SKIP: begin
            if (abort)                  state_d = S_DONE;
            else if (cnt_q == CNT_LAST) state_d = S_RUN;
         end
         S_RUN: begin
            if (abort || (byte_done && rem_q == LEN_W'(1))) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Registered outputs are derived from the state being entered.
   always_comb begin
      prs_reset_d = 1'b1;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      aborted_d   = 1'b0;
      unique case (state_d)
         S_RST:         busy_d = 1'b1;
         S_SKIP, S_RUN: begin
            prs_reset_d = 1'b0;
            busy_d      = 1'b1;
         end
         S_DONE: begin
            done_d    = 1'b1;
            aborted_d = abort && (state_q != S_IDLE);
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // sees the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         prs_reset  <= 1'b1;
         prs_taps   <= DEFAULT_TAPS;
         byte_data  <= '0;
         byte_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         cnt_q      <= '0;
         rem_q      <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
      end else begin
         state_q    <= state_d;
         prs_reset  <= prs_reset_d;
         busy       <= busy_d;
         done       <= done_d;
         aborted    <= aborted_d;
         byte_valid <= byte_done;

         if (accept) begin
            prs_taps <= cmd_taps;
            rem_q    <= cmd_len;
            cnt_q    <= RST_LOAD;
         end else if (state_q == S_RST) begin
            cnt_q <= (cnt_q == CNT_LAST) ? SKIP_LOAD : cnt_q - 1'b1;
         end else if (state_q == S_SKIP) begin
            cnt_q <= cnt_q - 1'b1;
         end

         // A partial byte is simply dropped when RUN is left early.
         if (state_q == S_RUN) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            shreg_q   <= {shreg_q[5:0], prs_bit};
            if (byte_done) begin
               byte_data <= {shreg_q, prs_bit};
               rem_q     <= rem_q - 1'b1;
            end
         end else begin
            bit_cnt_q <= '0;
         end
      end
   end

endmodule

// File: tb/tb_prs_burst_ctrl.sv
// Directed bench for prs_burst_ctrl: two instances (SKIP=0 and SKIP=3) fed by
// simple generator stubs that replay a bit pattern once prs_reset drops.
module tb_prs_burst_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // instance 0: SKIP = 0
   logic       cmd_valid0 = 1'b0, cmd_ready0, abort0 = 1'b0;
   logic [7:0] cmd_taps0 = '0, cmd_len0 = '0;
   logic       prs_reset0, prs_bit0, byte_valid0, busy0, done0, aborted0;
   logic [7:0] prs_taps0, byte_data0;
   logic [63:0] pat0 = '0;
   int unsigned idx0 = 0;

   // instance 1: SKIP = 3
   logic       cmd_valid1 = 1'b0, cmd_ready1, abort1 = 1'b0;
   logic [7:0] cmd_taps1 = '0, cmd_len1 = '0;
   logic       prs_reset1, prs_bit1, byte_valid1, busy1, done1, aborted1;
   logic [7:0] prs_taps1, byte_data1;
   logic [63:0] pat1 = '0;
   int unsigned idx1 = 0;

   prs_burst_ctrl #(.LEN_W(8), .RST_CYCLES(2), .SKIP(0), .DEFAULT_TAPS(8'hfe)) dut0 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
      .cmd_taps(cmd_taps0), .cmd_len(cmd_len0), .abort(abort0),
      .prs_reset(prs_reset0), .prs_taps(prs_taps0), .prs_bit(prs_bit0),
      .byte_data(byte_data0), .byte_valid(byte_valid0), .busy(busy0),
      .done(done0), .aborted(aborted0));

   prs_burst_ctrl #(.LEN_W(8), .RST_CYCLES(2), .SKIP(3), .DEFAULT_TAPS(8'hfe)) dut1 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
      .cmd_taps(cmd_taps1), .cmd_len(cmd_len1), .abort(abort1),
      .prs_reset(prs_reset1), .prs_taps(prs_taps1), .prs_bit(prs_bit1),
      .byte_data(byte_data1), .byte_valid(byte_valid1), .busy(busy1),
      .done(done1), .aborted(aborted1));

   // Generator stubs: bit idx is presented on the idx-th edge after prs_reset drops.
   assign prs_bit0 = pat0[63 - idx0];
   assign prs_bit1 = pat1[63 - idx1];
   always @(posedge clk) begin
      if (prs_reset0) idx0 <= 0; else if (idx0 < 63) idx0 <= idx0 + 1;
      if (prs_reset1) idx1 <= 0; else if (idx1 < 63) idx1 <= idx1 + 1;
   end

   logic [5:0] got, exp;  // {prs_reset, busy, byte_valid, done, aborted, cmd_ready}

   task automatic test_reset();
      repeat (2) @(negedge clk);
      tests++;
      if (cmd_ready0 !== 1'b0) begin
         fails++; $display("FAIL reset_cmd_ready got %b exp 0", cmd_ready0);
      end
      reset = 1'b0;
      repeat (5) @(negedge clk);
      got = {prs_reset0, busy0, byte_valid0, done0, aborted0, cmd_ready0};
      tests++;
      if (got !== 6'b100001) begin
         fails++; $display("FAIL reset_status got %b exp 100001", got);
      end
      tests++;
      if (prs_taps0 !== 8'hfe || byte_data0 !== 8'h00) begin
         fails++; $display("FAIL reset_taps_data got %h/%h exp fe/00", prs_taps0, byte_data0);
      end
      tests++;
      if (prs_reset1 !== 1'b1 || prs_taps1 !== 8'hfe || cmd_ready1 !== 1'b1) begin
         fails++; $display("FAIL reset_dut1 got %b/%h/%b exp 1/fe/1", prs_reset1, prs_taps1, cmd_ready1);
      end
   endtask

   task automatic test_two_bytes();
      pat0 = {32{2'b10}};
      cmd_valid0 = 1'b1; cmd_taps0 = 8'h80; cmd_len0 = 8'd2;
      @(posedge clk);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         cmd_valid0 = 1'b0;
         exp = {(c < 2 || c >= 18), (c < 18), (c == 10 || c == 18), (c == 18), 1'b0, (c == 19)};
         got = {prs_reset0, busy0, byte_valid0, done0, aborted0, cmd_ready0};
         tests++;
         if (got !== exp) begin
            fails++; $display("FAIL two_bytes_status c=%0d got %b exp %b", c, got, exp);
         end
         tests++;
         if (prs_taps0 !== 8'h80) begin
            fails++; $display("FAIL two_bytes_taps c=%0d got %h exp 80", c, prs_taps0);
         end
         if (c == 10 || c == 18) begin
            tests++;
            if (byte_data0 !== 8'haa) begin
               fails++; $display("FAIL two_bytes_data c=%0d got %h exp aa", c, byte_data0);
            end
         end
      end
   endtask

   task automatic test_skip();
      pat1 = {3'b111, 8'h0f, 53'd0};
      @(negedge clk);
      cmd_valid1 = 1'b1; cmd_taps1 = 8'h9c; cmd_len1 = 8'd1;
      @(posedge clk);
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         cmd_valid1 = 1'b0;
         exp = {(c < 2 || c >= 13), (c < 13), (c == 13), (c == 13), 1'b0, (c >= 14)};
         got = {prs_reset1, busy1, byte_valid1, done1, aborted1, cmd_ready1};
         tests++;
         if (got !== exp) begin
            fails++; $display("FAIL skip_status c=%0d got %b exp %b", c, got, exp);
         end
         if (c == 13) begin
            tests++;
            if (byte_data1 !== 8'h0f) begin
               fails++; $display("FAIL skip_data got %h exp 0f", byte_data1);
            end
         end
      end
   endtask

   task automatic test_zero_len();
      @(negedge clk);
      cmd_valid0 = 1'b1; cmd_taps0 = 8'h55; cmd_len0 = 8'd0;
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         cmd_valid0 = 1'b0;
         exp = {1'b1, 1'b0, 1'b0, (c == 0), 1'b0, (c >= 1)};
         got = {prs_reset0, busy0, byte_valid0, done0, aborted0, cmd_ready0};
         tests++;
         if (got !== exp) begin
            fails++; $display("FAIL zero_len_status c=%0d got %b exp %b", c, got, exp);
         end
         tests++;
         if (prs_taps0 !== 8'h55) begin
            fails++; $display("FAIL zero_len_taps c=%0d got %h exp 55", c, prs_taps0);
         end
      end
   endtask

   task automatic test_abort();
      pat0 = {8{8'h5a}};
      @(negedge clk);
      cmd_valid0 = 1'b1; cmd_taps0 = 8'hc3; cmd_len0 = 8'd4;
      @(posedge clk);
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         cmd_valid0 = 1'b0;
         exp = {(c < 2 || c >= 7), (c < 7), 1'b0, (c == 7), (c == 7), (c == 8)};
         got = {prs_reset0, busy0, byte_valid0, done0, aborted0, cmd_ready0};
         tests++;
         if (got !== exp) begin
            fails++; $display("FAIL abort_status c=%0d got %b exp %b", c, got, exp);
         end
         abort0 = (c == 6);
         if (c == 8) begin
            cmd_valid0 = 1'b1; cmd_taps0 = 8'h3c; cmd_len0 = 8'd0;
         end
      end
      @(negedge clk);
      cmd_valid0 = 1'b0;
      got = {prs_reset0, busy0, byte_valid0, done0, aborted0, cmd_ready0};
      tests++;
      if (got !== 6'b100100 || prs_taps0 !== 8'h3c) begin
         fails++; $display("FAIL abort_reaccept got %b/%h exp 100100/3c", got, prs_taps0);
      end
   endtask

   task automatic test_reset_mid_burst();
      bit seen;
      pat0 = {64{1'b1}};
      @(negedge clk);
      cmd_valid0 = 1'b1; cmd_taps0 = 8'h11; cmd_len0 = 8'd3;
      @(posedge clk);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tests++;
         if (busy0 !== 1'b1) begin
            fails++; $display("FAIL midrst_busy c=%0d got %b exp 1", c, busy0);
         end
         if (c == 4) reset = 1'b1;
      end
      for (int c = 5; c < 7; c++) begin
         @(negedge clk);
         got = {prs_reset0, busy0, byte_valid0, done0, aborted0, cmd_ready0};
         tests++;
         if (got !== 6'b100000 || prs_taps0 !== 8'hfe || byte_data0 !== 8'h00) begin
            fails++; $display("FAIL midrst_state c=%0d got %b/%h/%h exp 100000/fe/00",
                              c, got, prs_taps0, byte_data0);
         end
      end
      reset = 1'b0;
      #1;
      tests++;
      if (cmd_ready0 !== 1'b1) begin
         fails++; $display("FAIL midrst_ready got %b exp 1", cmd_ready0);
      end
      @(negedge clk);
      cmd_valid0 = 1'b0;
      got = {prs_reset0, busy0, byte_valid0, done0, aborted0, cmd_ready0};
      tests++;
      if (got !== 6'b110000 || prs_taps0 !== 8'h11) begin
         fails++; $display("FAIL midrst_accept got %b/%h exp 110000/11", got, prs_taps0);
      end
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (done0 === 1'b1) seen = 1'b1;
      end
      tests++;
      if (!seen) begin
         fails++; $display("FAIL midrst_done_timeout got 0 exp done within 60 cycles");
      end
   endtask

   initial begin
      test_reset();
      test_two_bytes();
      test_skip();
      test_zero_len();
      test_abort();
      test_reset_mid_burst();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
